// File: rtl/delay_event_scheduler.sv
// Shared delayed-event timer: round-robin arm, per-slot deadline fire.
// Optional macro DELAY_SCHED_CANCEL_EN adds req_cancel to abort armed slots.
module delay_event_scheduler #(
    parameter int NREQ     = 2,
    parameter int DW       = 16,
    parameter int TW       = 32,
    parameter int PREC_DIV = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_delay,
`ifdef DELAY_SCHED_CANCEL_EN
    input  logic [NREQ-1:0]   req_cancel,
`endif
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   busy,
    output logic [NREQ-1:0]   fire,
    output logic [NREQ*TW-1:0] fire_time,
    output logic [TW-1:0]     now_tick,
    output logic [TW-1:0]     now_unit
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW   = $clog2(PREC_DIV);
    localparam int HALF = (PREC_DIV + 1) / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_FIRE
    } slot_e;

    logic [TW-1:0] now_tick_q, now_tick_d;
    logic [TW-1:0] unit_q, unit_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    slot_e         state_q [NREQ];
    slot_e         state_d [NREQ];
    logic [TW-1:0] deadline_q [NREQ];
    logic [TW-1:0] deadline_d [NREQ];
    logic [TW-1:0] ftime_q [NREQ];
    logic [TW-1:0] ftime_d [NREQ];
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] cancel;
    logic [DW-1:0]   dly;

`ifdef DELAY_SCHED_CANCEL_EN
    assign cancel = req_cancel;
`else
    assign cancel = '0;
`endif

    // Tick, unit and sub-unit counters advance together on tick_en
    always_comb begin
        now_tick_d = now_tick_q;
        unit_d     = unit_q;
        sub_d      = sub_q;
        if (tick_en) begin
            now_tick_d = now_tick_q + TW'(1);
            if (sub_q == SW'(PREC_DIV - 1)) begin
                sub_d  = '0;
                unit_d = unit_q + TW'(1);
            end else begin
                sub_d = sub_q + SW'(1);
            end
        end
    end

    // Round-robin grant: first idle+valid slot at or after rr_ptr
    always_comb begin
        int   idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        grant    = '0;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req_valid[idx] && state_q[idx] == S_IDLE) begin
                grant[idx] = 1'b1;
                rr_ptr_d   = PW'((idx + 1) % NREQ);
                found      = 1'b1;
            end
        end
    end

    // Slot FSMs; the match looks at the next tick value so the pulse
    // lands in the cycle whose now_tick equals the deadline
    always_comb begin
        dly = '0;
        for (int i = 0; i < NREQ; i++) begin
            state_d[i]    = state_q[i];
            deadline_d[i] = deadline_q[i];
            ftime_d[i]    = ftime_q[i];
            dly           = req_delay[i*DW +: DW];
            unique case (state_q[i])
                S_IDLE: begin
                    if (grant[i]) begin
                        deadline_d[i] = now_tick_q +
                            ((dly == '0) ? TW'(1) : TW'(dly));
                        if (now_tick_d == deadline_d[i]) begin
                            state_d[i] = S_FIRE;
                            ftime_d[i] = deadline_d[i];
                        end else begin
                            state_d[i] = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (cancel[i]) begin
                        state_d[i] = S_IDLE;
                    end else if (now_tick_d == deadline_q[i]) begin
                        state_d[i] = S_FIRE;
                        ftime_d[i] = deadline_q[i];
                    end
                end
                S_FIRE: state_d[i] = S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_tick_q <= '0;
            unit_q     <= '0;
            sub_q      <= '0;
            rr_ptr_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                state_q[i]    <= S_IDLE;
                deadline_q[i] <= '0;
                ftime_q[i]    <= '0;
            end
        end else begin
            now_tick_q <= now_tick_d;
            unit_q     <= unit_d;
            sub_q      <= sub_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int i = 0; i < NREQ; i++) begin
                state_q[i]    <= state_d[i];
                deadline_q[i] <= deadline_d[i];
                ftime_q[i]    <= ftime_d[i];
            end
        end
    end

    // Per-slot status outputs
    always_comb begin
        busy      = '0;
        fire      = '0;
        fire_time = '0;
        for (int i = 0; i < NREQ; i++) begin
            busy[i] = (state_q[i] != S_IDLE);
            fire[i] = (state_q[i] == S_FIRE);
            fire_time[i*TW +: TW] = ftime_q[i];
        end
    end

    assign req_ready = grant;
    assign now_tick  = now_tick_q;
    assign now_unit  = unit_q + TW'(sub_q >= SW'(HALF));

endmodule

// File: tb/tb_delay_event_scheduler.sv
// Scoreboard bench for delay_event_scheduler.
// Build with DELAY_SCHED_CANCEL_EN to also exercise cancel.
module tb_delay_event_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_en;
    logic [1:0]  req_valid;
    logic [31:0] req_delay;
`ifdef DELAY_SCHED_CANCEL_EN
    logic [1:0]  req_cancel;
`endif
    logic [1:0]  req_ready, busy, fire;
    logic [63:0] fire_time;
    logic [31:0] now_tick, now_unit;

    logic        b_rst_n;
    logic        b_tick_en;
    logic [1:0]  b_valid;
    logic [11:0] b_delay;
`ifdef DELAY_SCHED_CANCEL_EN
    logic [1:0]  b_cancel;
`endif
    logic [1:0]  b_ready, b_busy, b_fire;
    logic [15:0] b_fire_time;
    logic [7:0]  b_now_tick, b_now_unit;

    logic [31:0] m_tick;
    logic [7:0]  b_m;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    delay_event_scheduler u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_en   (tick_en),
        .req_valid (req_valid),
        .req_delay (req_delay),
`ifdef DELAY_SCHED_CANCEL_EN
        .req_cancel(req_cancel),
`endif
        .req_ready (req_ready),
        .busy      (busy),
        .fire      (fire),
        .fire_time (fire_time),
        .now_tick  (now_tick),
        .now_unit  (now_unit)
    );

    delay_event_scheduler #(.NREQ(2), .DW(6), .TW(8), .PREC_DIV(10)) u_wrap (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .tick_en   (b_tick_en),
        .req_valid (b_valid),
        .req_delay (b_delay),
`ifdef DELAY_SCHED_CANCEL_EN
        .req_cancel(b_cancel),
`endif
        .req_ready (b_ready),
        .busy      (b_busy),
        .fire      (b_fire),
        .fire_time (b_fire_time),
        .now_tick  (b_now_tick),
        .now_unit  (b_now_unit)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input logic [31:0] t);
        for (int n = 0; n < 2000 && m_tick != t; n++) step();
    endtask

    // Reference time base
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_tick <= '0;
        else if (tick_en) m_tick <= m_tick + 32'd1;
    end

    always @(posedge clk or negedge b_rst_n) begin
        if (!b_rst_n) b_m <= '0;
        else if (b_tick_en) b_m <= b_m + 8'd1;
    end

    // Scoreboard: push on accept, pop and compare on fire
    always @(negedge clk) begin
        logic [31:0] e;
        logic [15:0] d;
        if (rst_n) begin
            if (fire[0]) begin
                if (q0.size() == 0) chk("fire0_unexpected", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("fire0_time", fire_time[31:0], e);
                    chk("fire0_tick", m_tick, e);
                end
            end
            if (fire[1]) begin
                if (q1.size() == 0) chk("fire1_unexpected", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("fire1_time", fire_time[63:32], e);
                    chk("fire1_tick", m_tick, e);
                end
            end
            if (req_valid[0] && req_ready[0]) begin
                d = req_delay[15:0];
                q0.push_back(m_tick + ((d == 0) ? 32'd1 : 32'(d)));
            end
            if (req_valid[1] && req_ready[1]) begin
                d = req_delay[31:16];
                q1.push_back(m_tick + ((d == 0) ? 32'd1 : 32'(d)));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit got_fire;
        rst_n     = 1'b0;
        b_rst_n   = 1'b0;
        tick_en   = 1'b0;
        b_tick_en = 1'b0;
        req_valid = '0;
        req_delay = '0;
        b_valid   = '0;
        b_delay   = '0;
`ifdef DELAY_SCHED_CANCEL_EN
        req_cancel = '0;
        b_cancel   = '0;
`endif
        step();
        step();
        chk("rst_tick", now_tick, 0);
        chk("rst_unit", now_unit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fire", fire, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_ftime", fire_time, 0);
        rst_n     = 1'b1;
        b_rst_n   = 1'b1;
        tick_en   = 1'b1;
        b_tick_en = 1'b1;

        // fractional delays 2.4 and 2.6 units
        wait_tick(10);
        req_valid = 2'b11;
        req_delay = {16'd26, 16'd24};
        #1 chk("arb_first", req_ready, 2'b01);
        step();
        req_valid = 2'b10;
        #1 chk("arb_second", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        wait_tick(20);
        chk("both_busy", busy, 2'b11);
        wait_tick(24);
        chk("unit_24", now_unit, 2);
        wait_tick(26);
        chk("unit_26", now_unit, 3);
        wait_tick(34);
        chk("tick_34", now_tick, 34);
        chk("unit_34", now_unit, 3);
        wait_tick(35);
        chk("tick_35", now_tick, 35);
        chk("unit_35", now_unit, 4);
        wait_tick(40);
        chk("idle_40", busy, 2'b00);

        // continuous requests alternate grants
        req_valid = 2'b11;
        req_delay = {16'd1, 16'd1};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("alt_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("alt_busy", busy, (k % 2 == 0) ? 2'b10 : 2'b01);
            step();
        end
        req_valid = 2'b00;
        step();
        step();

        // async reset while both slots armed
        wait_tick(60);
        req_valid = 2'b11;
        req_delay = {16'd100, 16'd100};
        step();
        step();
        req_valid = 2'b00;
        step();
        chk("pre_rst_busy", busy, 2'b11);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fire", fire, 0);
        chk("mid_rst_tick", now_tick, 0);
        step();
        step();
        rst_n = 1'b1;

        // zero delay behaves as one tick
        wait_tick(5);
        req_valid = 2'b01;
        req_delay = {16'd0, 16'd0};
        #1 chk("d0_grant", req_ready, 2'b01);
        step();
        req_valid = 2'b00;

        // stall while armed
        wait_tick(10);
        req_valid = 2'b10;
        req_delay = {16'd3, 16'd0};
        #1 chk("stall_grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        tick_en   = 1'b0;
        repeat (4) step();
        chk("stall_busy", busy, 2'b10);
        chk("stall_tick", now_tick, 11);
        tick_en = 1'b1;
        wait_tick(16);
        chk("stall_ftime", fire_time[63:32], 13);

`ifdef DELAY_SCHED_CANCEL_EN
        // cancel one tick ahead of the deadline
        wait_tick(30);
        req_valid = 2'b10;
        req_delay = {16'd5, 16'd0};
        step();
        req_valid = 2'b00;
        wait_tick(34);
        req_cancel = 2'b10;
        void'(q1.pop_back());
        step();
        req_cancel = 2'b00;
        wait_tick(40);
        chk("cancel_busy", busy, 0);
        chk("cancel_ftime", fire_time[63:32], 13);
`endif

        // deadline wrap on an 8-bit counter
        for (int n = 0; n < 600 && b_m != 8'd250; n++) step();
        b_valid = 2'b01;
        b_delay = {6'd0, 6'd10};
        #1 chk("wrap_grant", b_ready, 2'b01);
        step();
        b_valid  = 2'b00;
        got_fire = 1'b0;
        for (int n = 0; n < 20 && !got_fire; n++) begin
            if (b_fire[0]) begin
                got_fire = 1'b1;
                chk("wrap_tick", b_m, 4);
                chk("wrap_ftime", b_fire_time[7:0], 4);
            end else begin
                step();
            end
        end
        chk("wrap_seen", got_fire, 1);

        step();
        step();
        chk("pending0", q0.size(), 0);
        chk("pending1", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
